// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline hazard/stall controller: FSM states,
// forwarding select codes, register-number width and the hazard match rule.
package pipeline_pkg;

  localparam int unsigned REG_W = 5;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LD_STALL = 2'd1,
    ST_MD_WAIT  = 2'd2
  } state_e;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_MEM = 2'd1;
  localparam logic [1:0] FWD_WB  = 2'd2;

  // Register 0 is hardwired, so it never creates a dependency.
  function automatic logic reg_match(input logic [REG_W-1:0] src,
                                     input logic             used,
                                     input logic [REG_W-1:0] dst,
                                     input logic             we);
    return used && we && (src != '0) && (src == dst);
  endfunction

endpackage

// File: rtl/pipeline_ctrl_md_timer.sv
// Multiply/divide latency timer: loads latency-1 on start, counts down,
// holds busy for the whole latency and flags done in the final busy cycle.
module md_timer #(
  parameter int unsigned MULT_CYCLES = 4,
  parameter int unsigned DIV_CYCLES  = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start_i,
  input  logic is_div_i,
  output logic busy_o,
  output logic done_o
);

  localparam int unsigned MAX_LAT = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CW      = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
  localparam logic [CW-1:0] MULT_LD = CW'(MULT_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LD  = CW'(DIV_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  // done is registered yet coincides with the count==0 cycle, so it is
  // computed from the next count value.
  always_comb begin
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    if (start_i) begin
      cnt_d  = is_div_i ? DIV_LD : MULT_LD;
      busy_d = 1'b1;
      done_d = (cnt_d == '0);
    end else if (busy_q) begin
      if (cnt_q == '0) begin
        busy_d = 1'b0;
      end else begin
        cnt_d  = cnt_q - CW'(1);
        done_d = (cnt_d == '0);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// 5-stage pipeline hazard controller: load-use / data stalls, branch flushes,
// mult/div issue stall and operand forwarding (PIPELINE_CTRL_FWD_EN).
module pipeline_ctrl
  import pipeline_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 4,
  parameter int unsigned DIV_CYCLES  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_reg_write,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] mem_rd,
  input  logic             mem_reg_write,
  input  logic [REG_W-1:0] wb_rd,
  input  logic             wb_reg_write,
  input  logic             branch_taken,
  input  logic             md_start,
  input  logic             md_is_div,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             md_busy,
  output logic             md_done
);

  state_e state_q, state_d;
  logic   data_haz;
  logic   stall;
  logic   md_issue;
  logic   ex_hit_rs, ex_hit_rt, mem_hit_rs, mem_hit_rt;
  logic [1:0] fwd_a_raw, fwd_b_raw;

  assign ex_hit_rs  = reg_match(id_rs, id_uses_rs, ex_rd,  ex_reg_write);
  assign ex_hit_rt  = reg_match(id_rt, id_uses_rt, ex_rd,  ex_reg_write);
  assign mem_hit_rs = reg_match(id_rs, id_uses_rs, mem_rd, mem_reg_write);
  assign mem_hit_rt = reg_match(id_rt, id_uses_rt, mem_rd, mem_reg_write);

`ifdef PIPELINE_CTRL_FWD_EN
  localparam logic LD_ENTRY = 1'b1;
  logic wb_hit_rs, wb_hit_rt;

  assign wb_hit_rs = reg_match(id_rs, id_uses_rs, wb_rd, wb_reg_write);
  assign wb_hit_rt = reg_match(id_rt, id_uses_rt, wb_rd, wb_reg_write);
  assign data_haz  = ex_mem_read && (ex_hit_rs || ex_hit_rt);
  assign fwd_a_raw = mem_hit_rs ? FWD_MEM : (wb_hit_rs ? FWD_WB : FWD_RF);
  assign fwd_b_raw = mem_hit_rt ? FWD_MEM : (wb_hit_rt ? FWD_WB : FWD_RF);
`else
  // Without forwarding the stall is re-evaluated every cycle, so LD_STALL is never used.
  localparam logic LD_ENTRY = 1'b0;
  logic unused_nofwd;

  assign unused_nofwd = ^{ex_mem_read, wb_rd, wb_reg_write};
  assign data_haz  = ex_hit_rs || ex_hit_rt || mem_hit_rs || mem_hit_rt;
  assign fwd_a_raw = FWD_RF;
  assign fwd_b_raw = FWD_RF;
`endif

  always_comb begin
    state_d     = state_q;
    pc_en       = 1'b1;
    if_id_en    = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;

    // A taken branch squashes ID, so its stalls and mult/div issue are moot.
    stall    = !branch_taken &&
               ((data_haz && (state_q != ST_LD_STALL)) ||
                (md_start && (state_q == ST_MD_WAIT)));
    md_issue = md_start && !branch_taken && !stall && (state_q != ST_MD_WAIT);

    case (state_q)
      ST_RUN: begin
        if (md_issue)              state_d = ST_MD_WAIT;
        else if (LD_ENTRY && stall) state_d = ST_LD_STALL;
      end
      ST_LD_STALL: state_d = md_issue ? ST_MD_WAIT : ST_RUN;
      ST_MD_WAIT:  if (md_done) state_d = ST_RUN;
      default:     state_d = ST_RUN;
    endcase

    if (rst_n) begin
      pc_en       = !stall;
      if_id_en    = !stall;
      if_id_flush = branch_taken;
      id_ex_flush = branch_taken || stall;
    end
  end

  assign fwd_a = rst_n ? fwd_a_raw : FWD_RF;
  assign fwd_b = rst_n ? fwd_b_raw : FWD_RF;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_RUN;
    else        state_q <= state_d;
  end

  md_timer #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_md_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (md_issue),
    .is_div_i (md_is_div),
    .busy_o   (md_busy),
    .done_o   (md_done)
  );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios plus randomized
// traffic checked against a cycle-indexed behavioural model.
module tb_pipeline_ctrl;

  localparam int MULT_LAT = 4;
  localparam int DIV_LAT  = 32;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] id_rs, id_rt, ex_rd, mem_rd, wb_rd;
  logic       id_uses_rs, id_uses_rt, ex_reg_write, ex_mem_read;
  logic       mem_reg_write, wb_reg_write, branch_taken, md_start, md_is_div;
  logic       pc_en, if_id_en, if_id_flush, id_ex_flush, md_busy, md_done;
  logic [1:0] fwd_a, fwd_b;

  int total = 0;
  int bad   = 0;

  // model state: absolute cycle index, last mult/div issue, pending LD_STALL cycle
  int   cyc;
  bit   md_act;
  int   md_e;
  int   md_lat;
  bit   ld_act;
  int   ld_c;
  logic [9:0] exp_vec;
  bit   m_busy, m_stall, m_haz, m_inld;

  pipeline_ctrl #(
    .MULT_CYCLES (MULT_LAT),
    .DIV_CYCLES  (DIV_LAT)
  ) dut (
    .clk (clk), .rst_n (rst_n),
    .id_rs (id_rs), .id_rt (id_rt), .id_uses_rs (id_uses_rs), .id_uses_rt (id_uses_rt),
    .ex_rd (ex_rd), .ex_reg_write (ex_reg_write), .ex_mem_read (ex_mem_read),
    .mem_rd (mem_rd), .mem_reg_write (mem_reg_write),
    .wb_rd (wb_rd), .wb_reg_write (wb_reg_write),
    .branch_taken (branch_taken), .md_start (md_start), .md_is_div (md_is_div),
    .pc_en (pc_en), .if_id_en (if_id_en), .if_id_flush (if_id_flush), .id_ex_flush (id_ex_flush),
    .fwd_a (fwd_a), .fwd_b (fwd_b), .md_busy (md_busy), .md_done (md_done)
  );

  always #5 clk = ~clk;

  function automatic bit hit(input logic [4:0] r, input logic u, input logic [4:0] p, input logic we);
    return u && we && (r != 0) && (r == p);
  endfunction

  task automatic idle();
    id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
    ex_rd = 0; ex_reg_write = 0; ex_mem_read = 0;
    mem_rd = 0; mem_reg_write = 0; wb_rd = 0; wb_reg_write = 0;
    branch_taken = 0; md_start = 0; md_is_div = 0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic model_eval();
    bit ex_h, mem_h;
    logic [1:0] fa, fb;
    m_busy = md_act && (cyc >= md_e) && (cyc < md_e + md_lat);
    m_inld = ld_act && (cyc == ld_c);
    ex_h   = hit(id_rs, id_uses_rs, ex_rd, ex_reg_write) || hit(id_rt, id_uses_rt, ex_rd, ex_reg_write);
    mem_h  = hit(id_rs, id_uses_rs, mem_rd, mem_reg_write) || hit(id_rt, id_uses_rt, mem_rd, mem_reg_write);
`ifdef PIPELINE_CTRL_FWD_EN
    m_haz = ex_mem_read && ex_h && !m_inld;
    fa = hit(id_rs, id_uses_rs, mem_rd, mem_reg_write) ? 2'd1 :
         hit(id_rs, id_uses_rs, wb_rd, wb_reg_write)   ? 2'd2 : 2'd0;
    fb = hit(id_rt, id_uses_rt, mem_rd, mem_reg_write) ? 2'd1 :
         hit(id_rt, id_uses_rt, wb_rd, wb_reg_write)   ? 2'd2 : 2'd0;
`else
    m_haz = ex_h || mem_h;
    fa = 2'd0;
    fb = 2'd0;
`endif
    m_stall = !branch_taken && (m_haz || (md_start && m_busy));
    if (!rst_n)
      exp_vec = 10'b11_00_0000_00;
    else
      exp_vec = {!m_stall, !m_stall, branch_taken, branch_taken || m_stall, fa, fb,
                 m_busy, m_busy && (cyc == md_e + md_lat - 1)};
  endtask

  task automatic model_advance();
    if (!rst_n) begin
      md_act = 0;
      ld_act = 0;
    end else begin
      if (md_start && !branch_taken && !m_stall && !m_busy) begin
        md_act = 1;
        md_e   = cyc + 1;
        md_lat = md_is_div ? DIV_LAT : MULT_LAT;
      end
`ifdef PIPELINE_CTRL_FWD_EN
      if (m_haz && !branch_taken && !m_busy) begin
        ld_act = 1;
        ld_c   = cyc + 1;
      end
`endif
    end
    cyc++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    branch_taken = 1; md_start = 1; ex_mem_read = 1; ex_reg_write = 1; ex_rd = 2;
    id_rs = 2; id_uses_rs = 1; mem_rd = 2; mem_reg_write = 1;
    #2;
    total++;
    if ({pc_en, if_id_en, if_id_flush, id_ex_flush} !== 4'b1100) begin
      bad++; $display("FAIL reset_ctl got=%b want=1100", {pc_en, if_id_en, if_id_flush, id_ex_flush});
    end
    total++;
    if ({fwd_a, fwd_b} !== 4'b0000) begin
      bad++; $display("FAIL reset_fwd got=%b want=0000", {fwd_a, fwd_b});
    end
    @(posedge clk); #1;
    total++;
    if ({md_busy, md_done} !== 2'b00) begin
      bad++; $display("FAIL reset_md got=%b want=00", {md_busy, md_done});
    end
    idle();
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_load_use();
    idle();
    ex_mem_read = 1; ex_reg_write = 1; ex_rd = 2; id_rs = 2; id_uses_rs = 1;
    @(negedge clk);
    total++;
    if ({pc_en, if_id_en, if_id_flush, id_ex_flush} !== 4'b0001) begin
      bad++; $display("FAIL lu_stall got=%b want=0001", {pc_en, if_id_en, if_id_flush, id_ex_flush});
    end
    @(posedge clk); #1;
    ex_mem_read = 0; ex_reg_write = 0; ex_rd = 0; mem_rd = 2; mem_reg_write = 1;
    @(negedge clk);
`ifdef PIPELINE_CTRL_FWD_EN
    total++;
    if ({pc_en, if_id_en, id_ex_flush, fwd_a} !== 5'b110_01) begin
      bad++; $display("FAIL lu_release got=%b want=11001", {pc_en, if_id_en, id_ex_flush, fwd_a});
    end
`else
    total++;
    if ({pc_en, if_id_en, id_ex_flush, fwd_a} !== 5'b001_00) begin
      bad++; $display("FAIL lu_mem_stall got=%b want=00100", {pc_en, if_id_en, id_ex_flush, fwd_a});
    end
`endif
    @(posedge clk); #1;
    mem_rd = 0; mem_reg_write = 0; wb_rd = 2; wb_reg_write = 1;
    @(negedge clk);
    total++;
`ifdef PIPELINE_CTRL_FWD_EN
    if ({pc_en, id_ex_flush, fwd_a} !== 4'b10_10) begin
      bad++; $display("FAIL lu_wb got=%b want=1010", {pc_en, id_ex_flush, fwd_a});
    end
`else
    if ({pc_en, id_ex_flush, fwd_a} !== 4'b10_00) begin
      bad++; $display("FAIL lu_wb got=%b want=1000", {pc_en, id_ex_flush, fwd_a});
    end
`endif
    @(posedge clk); #1;
    idle();
  endtask

  task automatic test_fwd();
    logic [1:0] want_a;
    logic       want_pc;
    idle();
    mem_rd = 5; wb_rd = 5; mem_reg_write = 1; wb_reg_write = 1; id_rs = 5; id_uses_rs = 1;
    id_rt = 5; id_uses_rt = 1;
    @(negedge clk);
`ifdef PIPELINE_CTRL_FWD_EN
    want_a = 2'd1; want_pc = 1'b1;
`else
    want_a = 2'd0; want_pc = 1'b0;
`endif
    total++;
    if ({fwd_a, fwd_b, pc_en} !== {want_a, want_a, want_pc}) begin
      bad++; $display("FAIL fwd_mem_pref got=%b want=%b", {fwd_a, fwd_b, pc_en}, {want_a, want_a, want_pc});
    end
    @(posedge clk); #1;
    mem_reg_write = 0;
    @(negedge clk);
`ifdef PIPELINE_CTRL_FWD_EN
    want_a = 2'd2;
`else
    want_a = 2'd0;
`endif
    total++;
    if ({fwd_a, pc_en} !== {want_a, 1'b1}) begin
      bad++; $display("FAIL fwd_wb got=%b want=%b", {fwd_a, pc_en}, {want_a, 1'b1});
    end
    @(posedge clk); #1;
    mem_rd = 0; wb_rd = 0; mem_reg_write = 1; id_rs = 0; id_rt = 0;
    @(negedge clk);
    total++;
    if ({fwd_a, fwd_b, pc_en} !== 5'b00_00_1) begin
      bad++; $display("FAIL fwd_r0 got=%b want=00001", {fwd_a, fwd_b, pc_en});
    end
    @(posedge clk); #1;
    mem_rd = 5; id_rs = 5; id_uses_rs = 0; id_uses_rt = 0;
    @(negedge clk);
    total++;
    if ({fwd_a, pc_en} !== 3'b00_1) begin
      bad++; $display("FAIL fwd_unused got=%b want=001", {fwd_a, pc_en});
    end
    @(posedge clk); #1;
    idle();
  endtask

  task automatic test_md();
    logic [3:0] want_ctl;
    logic [1:0] want_md;
    idle();
    md_start = 1; md_is_div = 1;
    @(negedge clk);
    total++;
    if ({pc_en, id_ex_flush, md_busy} !== 3'b100) begin
      bad++; $display("FAIL md_issue got=%b want=100", {pc_en, id_ex_flush, md_busy});
    end
    @(posedge clk); #1;
    md_is_div = 0;
    for (int k = 1; k <= 34; k++) begin
      md_start     = (k >= 5) && (k <= 33);
      branch_taken = (k == 10);
      @(negedge clk);
      want_md = {(k <= DIV_LAT) || (k == 34), k == DIV_LAT};
      total++;
      if ({md_busy, md_done} !== want_md) begin
        bad++; $display("FAIL md_cnt k=%0d got=%b want=%b", k, {md_busy, md_done}, want_md);
      end
      if (k == 10)                   want_ctl = 4'b1111;
      else if (k >= 5 && k <= 32)    want_ctl = 4'b0001;
      else                           want_ctl = 4'b1100;
      total++;
      if ({pc_en, if_id_en, if_id_flush, id_ex_flush} !== want_ctl) begin
        bad++; $display("FAIL md_ctl k=%0d got=%b want=%b", k,
                        {pc_en, if_id_en, if_id_flush, id_ex_flush}, want_ctl);
      end
      @(posedge clk); #1;
    end
    do_reset();
  endtask

  task automatic test_branch();
    idle();
    ex_mem_read = 1; ex_reg_write = 1; ex_rd = 7; id_rt = 7; id_uses_rt = 1; branch_taken = 1;
    @(negedge clk);
    total++;
    if ({pc_en, if_id_en, if_id_flush, id_ex_flush} !== 4'b1111) begin
      bad++; $display("FAIL br_override got=%b want=1111", {pc_en, if_id_en, if_id_flush, id_ex_flush});
    end
    @(posedge clk); #1;
    branch_taken = 0;
    @(negedge clk);
    total++;
    if ({pc_en, if_id_en, if_id_flush, id_ex_flush} !== 4'b0001) begin
      bad++; $display("FAIL br_no_ldstall got=%b want=0001", {pc_en, if_id_en, if_id_flush, id_ex_flush});
    end
    @(posedge clk); #1;
    idle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int seen;
    idle();
    md_start = 1; md_is_div = 1;
    @(posedge clk); #1;
    idle();
    repeat (21) @(posedge clk);
    #2;
    total++;
    if (md_busy !== 1'b1) begin
      bad++; $display("FAIL rmid_busy_before got=%b want=1", md_busy);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({md_busy, md_done} !== 2'b00) begin
      bad++; $display("FAIL rmid_async got=%b want=00", {md_busy, md_done});
    end
    #3 rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (md_busy || md_done) seen++;
    end
    total++;
    if (seen !== 0) begin
      bad++; $display("FAIL rmid_no_done got=%0d active cycles want=0", seen);
    end
  endtask

  task automatic test_nofwd_hold();
    idle();
    ex_rd = 3; ex_reg_write = 1; id_rt = 3; id_uses_rt = 1;
    @(negedge clk);
    total++;
`ifdef PIPELINE_CTRL_FWD_EN
    if (pc_en !== 1'b1) begin
      bad++; $display("FAIL hold_c1 got=%b want=1", pc_en);
    end
`else
    if ({pc_en, id_ex_flush} !== 2'b01) begin
      bad++; $display("FAIL hold_c1 got=%b want=01", {pc_en, id_ex_flush});
    end
`endif
    @(posedge clk); #1;
    ex_rd = 0; ex_reg_write = 0; mem_rd = 3; mem_reg_write = 1;
    @(negedge clk);
    total++;
`ifdef PIPELINE_CTRL_FWD_EN
    if ({pc_en, fwd_b} !== 3'b1_01) begin
      bad++; $display("FAIL hold_c2 got=%b want=101", {pc_en, fwd_b});
    end
`else
    if ({pc_en, id_ex_flush} !== 2'b01) begin
      bad++; $display("FAIL hold_c2 got=%b want=01", {pc_en, id_ex_flush});
    end
`endif
    @(posedge clk); #1;
    mem_rd = 0; mem_reg_write = 0; wb_rd = 3; wb_reg_write = 1;
    @(negedge clk);
    total++;
    if ({pc_en, id_ex_flush} !== 2'b10) begin
      bad++; $display("FAIL hold_c3 got=%b want=10", {pc_en, id_ex_flush});
    end
    @(posedge clk); #1;
    idle();
  endtask

  task automatic test_random();
    logic [9:0] got;
    do_reset();
    cyc = 0; md_act = 0; ld_act = 0; md_e = 0; md_lat = 0; ld_c = 0;
    for (int n = 0; n < 1500; n++) begin
      rst_n         = ($urandom_range(0, 99) != 0);
      id_rs         = 5'($urandom_range(0, 3));
      id_rt         = 5'($urandom_range(0, 3));
      id_uses_rs    = 1'($urandom_range(0, 1));
      id_uses_rt    = 1'($urandom_range(0, 1));
      ex_rd         = 5'($urandom_range(0, 3));
      ex_reg_write  = 1'($urandom_range(0, 1));
      ex_mem_read   = 1'($urandom_range(0, 1));
      mem_rd        = 5'($urandom_range(0, 3));
      mem_reg_write = 1'($urandom_range(0, 1));
      wb_rd         = 5'($urandom_range(0, 3));
      wb_reg_write  = 1'($urandom_range(0, 1));
      branch_taken  = ($urandom_range(0, 7) == 0);
      md_start      = ($urandom_range(0, 5) == 0);
      md_is_div     = ($urandom_range(0, 3) == 0);
      @(negedge clk);
      model_eval();
      got = {pc_en, if_id_en, if_id_flush, id_ex_flush, fwd_a, fwd_b, md_busy, md_done};
      total++;
      if (got !== exp_vec) begin
        bad++; $display("FAIL rnd n=%0d got=%b want=%b", n, got, exp_vec);
      end
      @(posedge clk);
      model_advance();
      #1;
    end
    idle();
    rst_n = 1'b1;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    test_reset();
    test_load_use();
    test_fwd();
    test_md();
    test_branch();
    test_reset_mid();
    test_nofwd_hold();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameters SHALL be: MULT_CYCLES, default 4, multiply latency in cycles; DIV_CYCLES, default 32, divide latency in cycles.
REQ-002 Ports SHALL be, in order: clk in 1 sole clock, rising edge; rst_n in 1 asynchronous active-low reset.
REQ-003 id_rs, id_rt in 5 each: ID-stage source register numbers; id_uses_rs, id_uses_rt in 1 each: source valid.
REQ-004 ex_rd in 5, ex_reg_write in 1, ex_mem_read in 1: EX-stage producer.
REQ-005 mem_rd in 5, mem_reg_write in 1: MEM-stage producer; wb_rd in 5, wb_reg_write in 1: WB-stage producer from the MEM/WB register.
REQ-006 branch_taken in 1: EX-resolved redirect (branch or jr); md_start in 1, md_is_div in 1: ID issues mult/div.
REQ-007 pc_en out 1, if_id_en out 1, if_id_flush out 1, id_ex_flush out 1: pipeline-register controls.
REQ-008 fwd_a, fwd_b out 2 each: operand select, 0=regfile, 1=MEM, 2=WB; md_busy out 1; md_done out 1 (one-cycle pulse).

Function
REQ-009 A hazard match SHALL require a nonzero register number, the valid flag, and the producer's write enable; register 0 never matches.
REQ-010 FSM states SHALL be RUN, LD_STALL, MD_WAIT (2-bit state register).
REQ-011 RUN: load-use (ex_mem_read and EX match on a used source) SHALL drive pc_en=0, if_id_en=0, id_ex_flush=1 in the same cycle and go to LD_STALL.
REQ-012 LD_STALL SHALL last exactly one cycle with pc_en=if_id_en=1, then return to RUN; total bubble is one cycle.
REQ-013 RUN with md_start SHALL load the counter with MULT_CYCLES-1 or DIV_CYCLES-1 (md_is_div), set md_busy, and go to MD_WAIT; the issuing instruction advances.
REQ-014 MD_WAIT SHALL decrement the counter each cycle; at count 0 it SHALL pulse md_done for one cycle, clear md_busy, and return to RUN.
REQ-015 In MD_WAIT, md_start in ID SHALL stall (pc_en=0, if_id_en=0, id_ex_flush=1) until the state returns to RUN; other instructions proceed.
REQ-016 branch_taken SHALL assert if_id_flush=1 and id_ex_flush=1 that cycle with pc_en=1; it overrides load-use and md_start stall in the same cycle, and the FSM SHALL NOT enter LD_STALL.
REQ-017 branch_taken SHALL NOT cancel an in-flight MD_WAIT count.
REQ-018 Forwarding SHALL prefer the MEM match over the WB match for the same register; otherwise 0.
REQ-019 Counter width SHALL be clog2 of the larger latency; MULT_CYCLES, DIV_CYCLES >= 1 (value 1: md_done the cycle after issue).
REQ-020 All control outputs except md_busy and md_done SHALL be combinational from inputs and state; md_busy and md_done SHALL be registered.

Reset
REQ-021 rst_n low SHALL immediately force state=RUN, counter=0, md_busy=0, md_done=0, including mid MD_WAIT or LD_STALL; no md_done is emitted for an aborted operation.
REQ-022 During reset, pc_en=if_id_en=1, flushes=0, fwd_a=fwd_b=0.

Configuration
REQ-023 Macro PIPELINE_CTRL_FWD_EN defined: forwarding per REQ-018; stalls only on load-use.
REQ-024 Macro undefined: fwd_a=fwd_b=0 always; any used source matching the EX or MEM producer SHALL stall as in REQ-011 (re-evaluated every cycle in RUN); the WB match is covered by the write-first regfile.

Structure
REQ-025 Shared package pipeline_pkg SHALL hold the state enum, fwd select constants (FWD_RF, FWD_MEM, FWD_WB) and the register-number width.
REQ-026 A sub-module md_timer (counter, busy, done pulse) is natural; hazard compare stays inline.

Verification
REQ-027 lw r2 in EX (ex_mem_read=1, ex_rd=2), ID uses rs=2 -> one cycle pc_en=0, id_ex_flush=1, then RUN; with FWD_EN, fwd_a=1 next cycle.
REQ-028 mem_rd=wb_rd=5, both writing, id_rs=5 -> fwd_a=1; mem_reg_write=0 -> fwd_a=2; id_rs=0 -> fwd_a=0.
REQ-029 md_start, md_is_div=1 -> md_busy for 32 cycles, md_done single pulse in cycle 32; second md_start during wait stalls until RUN.
REQ-030 branch_taken with a load-use hazard in the same cycle -> both flushes=1, pc_en=1, no LD_STALL entered.
REQ-031 rst_n low at count 10 of a divide -> md_busy=0 immediately, no md_done afterwards.
REQ-032 FWD_EN undefined, ex_rd=3 writing, id_rt=3 used -> stall each cycle until the producer leaves MEM (two stall cycles).
